ram_partition_ctrl: RTL and testbench

RAM_PARTITION_CTRL -- requirements
Module: ram_partition_ctrl

---
 rtl/ram_part_pkg.sv | 38 +++
 rtl/ram_part_wake_timer.sv | 44 ++++
 rtl/ram_partition_ctrl.sv | 150 +++++++++++++++
 tb/tb_ram_partition_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_part_pkg.sv
//----------------------------------------------------------------------------
// Module   : ram_part_pkg
// Purpose  : Shared types and helpers for the RAM partition controller:
//            FSM state encoding, partition count and the gate-mask mapping.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package ram_part_pkg;

  localparam int NUM_PARTITIONS = 4;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SWITCH = 3'd3,
    ST_WAKE   = 3'd4,
    ST_ACK    = 3'd5
  } state_t;

  // Shrinking the address space by one bit frees the top half of the RAM
  // (partitions 3,2); by two or more bits it frees all but partition 0.
  function automatic logic [NUM_PARTITIONS-1:0] gate_mask(input logic [31:0] index,
                                                          input logic [31:0] active);
    logic [31:0] d;
    d = index - ((active < index) ? active : index);
    if (d == 32'd0)
      gate_mask = 4'b0000;
    else if (d == 32'd1)
      gate_mask = 4'b1100;
    else
      gate_mask = 4'b1110;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_part_wake_timer.sv
//----------------------------------------------------------------------------
// Module   : ram_part_wake_timer
// Purpose  : Down-counter timing the settle window after partitions are
//            ungated. done_o flags the final settle cycle.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module ram_part_wake_timer #(
  parameter int WAKE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = 8'(WAKE_CYCLES);
    else if (dec_i && (count_q != 8'd0))
      count_d = count_q - 8'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset)
      count_q <= 8'd0;
    else
      count_q <= count_d;
  end

  // Loaded with N, so the cycle holding 1 is the Nth cycle of the window.
  assign done_o = (count_q == 8'd1);

endmodule

`default_nettype wire

// File: rtl/ram_partition_ctrl.sv
//----------------------------------------------------------------------------
// Module   : ram_partition_ctrl
// Purpose  : Sequences resizing of a partitioned RAM: stalls upstream, drains
//            pending writes, updates per-partition power gates, optionally
//            waits for ungated partitions to settle, then acknowledges.
// Config   : RAM_PART_WAKE_WAIT_EN - when defined, ungating any partition
//            inserts a WAKE_CYCLES settle window before the acknowledge.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module ram_partition_ctrl
  import ram_part_pkg::*;
#(
  parameter int INDEX       = 7,
  parameter int AIDX_W      = 4,
  parameter int WAKE_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AIDX_W-1:0]         activeIndex_i,
  input  logic                      resizeReq_i,
  output logic                      resizeAck_o,
  input  logic                      ramReady_i,
  input  logic                      wrInFlight_i,
  output logic [NUM_PARTITIONS-1:0] partitionGated_o,
  output logic                      stall_o
);

  state_t                    state_q, state_d;
  logic [AIDX_W-1:0]         idx_q, idx_d;
  logic [NUM_PARTITIONS-1:0] gated_q, gated_d;
  logic                      stall_q, stall_d;
  logic                      ack_q, ack_d;
  logic [NUM_PARTITIONS-1:0] new_mask;
  logic                      wake_load;
  logic                      wake_dec;
  logic                      wake_done;

  assign new_mask = gate_mask(32'(INDEX), 32'(idx_q));

  ram_part_wake_timer #(
    .WAKE_CYCLES (WAKE_CYCLES)
  ) u_wake_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (wake_load),
    .dec_i  (wake_dec),
    .done_o (wake_done)
  );

  // Next-state and next-output logic; outputs are computed one edge ahead
  // so every port is driven straight from a flop.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gated_d   = gated_q;
    stall_d   = stall_q;
    ack_d     = 1'b0;
    wake_load = 1'b0;
    wake_dec  = 1'b0;

    case (state_q)
      ST_INIT: begin
        stall_d = 1'b1;
        if (ramReady_i)
          state_d = ST_IDLE;
      end
      ST_IDLE: begin
        stall_d = 1'b0;
        if (resizeReq_i) begin
          idx_d   = activeIndex_i;
          stall_d = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        stall_d = 1'b1;
        if (!wrInFlight_i)
          state_d = ST_SWITCH;
      end
      ST_SWITCH: begin
        gated_d = new_mask;
`ifdef RAM_PART_WAKE_WAIT_EN
        // Only powering a partition back up needs a settle window.
        if ((gated_q & ~new_mask) != '0) begin
          state_d   = ST_WAKE;
          wake_load = 1'b1;
        end else begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end
`else
        state_d = ST_ACK;
        ack_d   = 1'b1;
`endif
      end
      ST_WAKE: begin
        wake_dec = 1'b1;
        if (wake_done) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end
      end
      ST_ACK: begin
        stall_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
        stall_d = 1'b1;
      end
    endcase

    // Losing RAM readiness aborts any operation; gates stay as they are so
    // partitions are not toggled while the RAM re-initialises.
    if ((state_q != ST_INIT) && !ramReady_i) begin
      state_d   = ST_INIT;
      stall_d   = 1'b1;
      ack_d     = 1'b0;
      wake_load = 1'b0;
      gated_d   = gated_q;
      idx_d     = idx_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      idx_q   <= AIDX_W'(INDEX);
      gated_q <= '0;
      stall_q <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gated_q <= gated_d;
      stall_q <= stall_d;
      ack_q   <= ack_d;
    end
  end

  assign partitionGated_o = gated_q;
  assign stall_o          = stall_q;
  assign resizeAck_o      = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_partition_ctrl.sv
//----------------------------------------------------------------------------
// Module   : tb_ram_partition_ctrl
// Purpose  : Directed self-checking bench for ram_partition_ctrl.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_ram_partition_ctrl;

  localparam int W = 8;
`ifdef RAM_PART_WAKE_WAIT_EN
  localparam int WX = W;
`else
  localparam int WX = 0;
`endif

  logic       clk           = 1'b0;
  logic       reset         = 1'b1;
  logic [3:0] activeIndex_i = 4'd0;
  logic       resizeReq_i   = 1'b0;
  logic       ramReady_i    = 1'b0;
  logic       wrInFlight_i  = 1'b0;
  logic       resizeAck_o;
  logic [3:0] partitionGated_o;
  logic       stall_o;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  // Results of the last do_resize call
  int         r_ack_edge;
  int         r_ack_cnt;
  int         r_gate_edge;
  int         r_stall_low_early;
  int         r_stall_after;
  logic [3:0] r_gated;

  ram_partition_ctrl #(
    .INDEX       (7),
    .AIDX_W      (4),
    .WAKE_CYCLES (W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .activeIndex_i    (activeIndex_i),
    .resizeReq_i      (resizeReq_i),
    .resizeAck_o      (resizeAck_o),
    .ramReady_i       (ramReady_i),
    .wrInFlight_i     (wrInFlight_i),
    .partitionGated_o (partitionGated_o),
    .stall_o          (stall_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  // Issue one resize; edges are counted from the acceptance edge (=1).
  // wrInFlight_i is high for the first n_wr edges.
  task automatic do_resize(input logic [3:0] idx, input int n_wr);
    logic [3:0] g_prev;
    int e;
    g_prev            = partitionGated_o;
    r_ack_edge        = -1;
    r_ack_cnt         = 0;
    r_gate_edge       = -1;
    r_stall_low_early = 0;
    r_stall_after     = -1;
    activeIndex_i     = idx;
    resizeReq_i       = 1'b1;
    wrInFlight_i      = (n_wr > 0);
    e = 0;
    while (e < 60 && (r_ack_edge < 0 || e < r_ack_edge + 3)) begin
      tick();
      e++;
      if (e >= n_wr) wrInFlight_i = 1'b0;
      if (r_ack_edge < 0 && !stall_o) r_stall_low_early = 1;
      if (r_ack_edge >= 0 && e == r_ack_edge + 1) r_stall_after = int'(stall_o);
      if (resizeAck_o) begin
        r_ack_cnt++;
        if (r_ack_edge < 0) begin
          r_ack_edge  = e;
          resizeReq_i = 1'b0;
        end
      end
      if (r_gate_edge < 0 && partitionGated_o !== g_prev) r_gate_edge = e;
    end
    resizeReq_i  = 1'b0;
    wrInFlight_i = 1'b0;
    r_gated      = partitionGated_o;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b expected 1", stall_o); end
    n_checks++; if (resizeAck_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", resizeAck_o); end
    n_checks++; if (partitionGated_o !== 4'b0000) begin n_fail++; $display("FAIL reset_gated: got %b expected 0000", partitionGated_o); end
  endtask

  task automatic test_ready_release();
    int bad;
    bad   = 0;
    reset = 1'b0;
    resizeReq_i = 1'b1;   // must be ignored while in INIT
    while (edge_cnt < 19) begin
      tick();
      if (stall_o !== 1'b1 || resizeAck_o !== 1'b0) bad++;
    end
    resizeReq_i = 1'b0;
    ramReady_i  = 1'b1;
    tick();  // edge 20: ramReady sampled
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL init_hold: %0d bad cycles, expected 0", bad); end
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL release_stall_c21: got %b expected 1", stall_o); end
    tick();  // edge 21
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL release_stall_c22: got %b expected 0", stall_o); end
    n_checks++; if (partitionGated_o !== 4'b0000) begin n_fail++; $display("FAIL release_gated: got %b expected 0000", partitionGated_o); end
  endtask

  task automatic test_shrink_one();
    do_resize(4'd6, 0);
    n_checks++; if (r_gated !== 4'b1100) begin n_fail++; $display("FAIL shrink1_mask: got %b expected 1100", r_gated); end
    n_checks++; if (r_ack_edge != 3) begin n_fail++; $display("FAIL shrink1_ack_edge: got %0d expected 3", r_ack_edge); end
    n_checks++; if (r_ack_cnt != 1) begin n_fail++; $display("FAIL shrink1_ack_count: got %0d expected 1", r_ack_cnt); end
    n_checks++; if (r_stall_low_early != 0 || r_stall_after != 0) begin n_fail++;
      $display("FAIL shrink1_stall: early_low=%0d after_ack=%0d expected 0/0", r_stall_low_early, r_stall_after); end
  endtask

  task automatic test_shrink_two();
    do_resize(4'd2, 0);
    n_checks++; if (r_gated !== 4'b1110) begin n_fail++; $display("FAIL shrink2_mask: got %b expected 1110", r_gated); end
    n_checks++; if (r_ack_edge != 3) begin n_fail++; $display("FAIL shrink2_ack_edge: got %0d expected 3", r_ack_edge); end
  endtask

  task automatic test_grow_wake();
    do_resize(4'd7, 0);
    n_checks++; if (r_gated !== 4'b0000) begin n_fail++; $display("FAIL grow_mask: got %b expected 0000", r_gated); end
    n_checks++; if (r_gate_edge != 3) begin n_fail++; $display("FAIL grow_gate_edge: got %0d expected 3", r_gate_edge); end
    n_checks++; if (r_ack_edge != 3 + WX) begin n_fail++; $display("FAIL grow_ack_edge: got %0d expected %0d", r_ack_edge, 3 + WX); end
    n_checks++; if (r_ack_cnt != 1) begin n_fail++; $display("FAIL grow_ack_count: got %0d expected 1", r_ack_cnt); end
    n_checks++; if (r_stall_low_early != 0 || r_stall_after != 0) begin n_fail++;
      $display("FAIL grow_stall: early_low=%0d after_ack=%0d expected 0/0", r_stall_low_early, r_stall_after); end
  endtask

  task automatic test_same_mask();
    do_resize(4'd7, 0);
    n_checks++; if (r_gated !== 4'b0000 || r_gate_edge != -1) begin n_fail++;
      $display("FAIL same_mask: got %b edge %0d expected 0000 edge -1", r_gated, r_gate_edge); end
    n_checks++; if (r_ack_edge != 3 || r_ack_cnt != 1) begin n_fail++;
      $display("FAIL same_ack: edge %0d count %0d expected 3/1", r_ack_edge, r_ack_cnt); end
  endtask

  task automatic test_drain();
    do_resize(4'd6, 5);
    n_checks++; if (r_gate_edge != 7) begin n_fail++; $display("FAIL drain_gate_edge: got %0d expected 7", r_gate_edge); end
    n_checks++; if (r_ack_edge != 7) begin n_fail++; $display("FAIL drain_ack_edge: got %0d expected 7", r_ack_edge); end
    n_checks++; if (r_stall_low_early != 0) begin n_fail++; $display("FAIL drain_stall: early_low=%0d expected 0", r_stall_low_early); end
    n_checks++; if (r_gated !== 4'b1100) begin n_fail++; $display("FAIL drain_mask: got %b expected 1100", r_gated); end
  endtask

  task automatic test_ready_drop();
    tick();
    ramReady_i = 1'b0;
    tick();
    n_checks++; if (stall_o !== 1'b1 || partitionGated_o !== 4'b1100) begin n_fail++;
      $display("FAIL drop_hold: stall %b gated %b expected 1/1100", stall_o, partitionGated_o); end
    resizeReq_i   = 1'b1;
    activeIndex_i = 4'd7;
    tick();
    n_checks++; if (stall_o !== 1'b1 || resizeAck_o !== 1'b0) begin n_fail++;
      $display("FAIL drop_ignore_req: stall %b ack %b expected 1/0", stall_o, resizeAck_o); end
    resizeReq_i = 1'b0;
    ramReady_i  = 1'b1;
    tick();
    tick();
    n_checks++; if (stall_o !== 1'b0 || partitionGated_o !== 4'b1100) begin n_fail++;
      $display("FAIL drop_recover: stall %b gated %b expected 0/1100", stall_o, partitionGated_o); end
  endtask

  task automatic test_reset_mid();
    int acks;
    acks          = 0;
    activeIndex_i = 4'd7;
    resizeReq_i   = 1'b1;
`ifdef RAM_PART_WAKE_WAIT_EN
    wrInFlight_i  = 1'b0;
    repeat (5) begin tick(); if (resizeAck_o) acks++; end   // now inside WAKE
`else
    wrInFlight_i  = 1'b1;
    repeat (3) begin tick(); if (resizeAck_o) acks++; end   // now inside DRAIN
`endif
    reset = 1'b1;
    tick();
    if (resizeAck_o) acks++;
    n_checks++; if (stall_o !== 1'b1 || partitionGated_o !== 4'b0000) begin n_fail++;
      $display("FAIL midreset_state: stall %b gated %b expected 1/0000", stall_o, partitionGated_o); end
    resizeReq_i  = 1'b0;
    wrInFlight_i = 1'b0;
    tick();
    if (resizeAck_o) acks++;
    reset = 1'b0;
    repeat (4) begin tick(); if (resizeAck_o) acks++; end
    n_checks++; if (acks != 0) begin n_fail++; $display("FAIL midreset_ack: got %0d pulses expected 0", acks); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL midreset_recover: stall %b expected 0", stall_o); end
  endtask

  task automatic test_out_of_range();
    do_resize(4'd2, 0);
    n_checks++; if (r_gated !== 4'b1110) begin n_fail++; $display("FAIL idx2_mask: got %b expected 1110", r_gated); end
    do_resize(4'd15, 0);
    n_checks++; if (r_gated !== 4'b0000) begin n_fail++; $display("FAIL idx15_mask: got %b expected 0000", r_gated); end
    n_checks++; if (r_ack_edge != 3 + WX || r_ack_cnt != 1) begin n_fail++;
      $display("FAIL idx15_ack: edge %0d count %0d expected %0d/1", r_ack_edge, r_ack_cnt, 3 + WX); end
  endtask

  initial begin
    test_reset();
    test_ready_release();
    test_shrink_one();
    test_shrink_two();
    test_grow_wake();
    test_same_mask();
    test_drain();
    test_ready_drop();
    test_reset_mid();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
